univ_shift_reg_n: RTL

//  Parametrised universal shift register with internally held state: load, hold,

---
 rtl/univ_shift_reg_n_if.sv | 31 +++
 rtl/univ_shift_reg_n.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg_n_if.sv
// Bus bundle for univ_shift_reg_n: control and data inputs, register and
// serializer outputs, plus the FSM state for observation.
interface univ_shift_reg_n_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2:0]       op;
  logic [WIDTH-1:0] data_in;
  logic             serial_in;
  logic [CNT_W-1:0] shamt;
  logic             abort;
  logic [WIDTH-1:0] q;
  logic             serial_out;
  logic             ser_valid;
  logic             busy;
  logic             done;
  logic             fsm_state;

  // ser_valid is a valid-only strobe with no ready: the consumer must take
  // serial_out on every cycle ser_valid is high; done marks the last bit.
  modport master (
    output op, data_in, serial_in, shamt, abort,
    input  q, serial_out, ser_valid, busy, done, fsm_state
  );

  modport slave (
    input  op, data_in, serial_in, shamt, abort,
    output q, serial_out, ser_valid, busy, done, fsm_state
  );
endinterface

// File: rtl/univ_shift_reg_n.sv
// Universal shift register with an MSB-first self-timed serializer.
// Optional USR_BARREL_SHIFT_EN: shifts/rotates move q by shamt in one cycle.
module univ_shift_reg_n #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic             clk,
  input logic             rst,
  univ_shift_reg_n_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] W_C  = CNT_W'(WIDTH);
  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ASR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ROR  = 3'b110;
  localparam logic [2:0] OP_SER  = 3'b111;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] q_r, q_nx;
  logic             so_r, so_nx;
  logic             valid_r, valid_nx;
  logic             done_r, done_nx;
  logic [CNT_W-1:0] cnt_r, cnt_nx;
  logic [WIDTH-1:0] sh_q;
  logic             sh_so;

`ifdef USR_BARREL_SHIFT_EN
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ONES = '1;
  logic [CNT_W-1:0] rot;
  logic             sat;
  logic             fill_r;

  // shamt never reaches 2*WIDTH, so one conditional subtract gives the modulo.
  always_comb begin
    sh_q   = q_r;
    sh_so  = 1'b0;
    sat    = (bus.shamt >= W_C);
    rot    = sat ? bus.shamt - W_C : bus.shamt;
    fill_r = (bus.op == OP_ASR) ? q_r[WIDTH-1] : bus.serial_in;
    case (bus.op)
      OP_SHL: begin
        if (sat) begin
          sh_q  = {WIDTH{bus.serial_in}};
          sh_so = q_r[0];
        end else if (bus.shamt != '0) begin
          sh_q  = (q_r << bus.shamt) | (~(ONES << bus.shamt) & {WIDTH{bus.serial_in}});
          sh_so = |(q_r & (ONE << (W_C - bus.shamt)));
        end
      end
      OP_SHR, OP_ASR: begin
        if (sat) begin
          sh_q  = {WIDTH{fill_r}};
          sh_so = q_r[WIDTH-1];
        end else if (bus.shamt != '0) begin
          sh_q  = (q_r >> bus.shamt) | (~(ONES >> bus.shamt) & {WIDTH{fill_r}});
          sh_so = |(q_r & (ONE << (bus.shamt - 1'b1)));
        end
      end
      OP_ROL: begin
        if (rot != '0) begin
          sh_q  = (q_r << rot) | (q_r >> (W_C - rot));
          sh_so = |(q_r & (ONE << (W_C - rot)));
        end
      end
      OP_ROR: begin
        if (rot != '0) begin
          sh_q  = (q_r >> rot) | (q_r << (W_C - rot));
          sh_so = |(q_r & (ONE << (rot - 1'b1)));
        end
      end
      default: ;
    endcase
  end
`else
  wire unused_shamt = ^bus.shamt;

  always_comb begin
    sh_q  = q_r;
    sh_so = 1'b0;
    case (bus.op)
      OP_SHL: begin sh_q = {q_r[WIDTH-2:0], bus.serial_in}; sh_so = q_r[WIDTH-1]; end
      OP_SHR: begin sh_q = {bus.serial_in, q_r[WIDTH-1:1]}; sh_so = q_r[0]; end
      OP_ASR: begin sh_q = {q_r[WIDTH-1], q_r[WIDTH-1:1]};  sh_so = q_r[0]; end
      OP_ROL: begin sh_q = {q_r[WIDTH-2:0], q_r[WIDTH-1]};  sh_so = q_r[WIDTH-1]; end
      OP_ROR: begin sh_q = {q_r[0], q_r[WIDTH-1:1]};        sh_so = q_r[0]; end
      default: ;
    endcase
  end
`endif

  always_comb begin
    state_nx = state;
    q_nx     = q_r;
    so_nx    = so_r;
    valid_nx = 1'b0;
    done_nx  = 1'b0;
    cnt_nx   = cnt_r;
    case (state)
      IDLE: begin
        case (bus.op)
          OP_HOLD: so_nx = 1'b0;
          OP_LOAD: begin q_nx = bus.data_in; so_nx = 1'b0; end
          OP_SER: begin
            q_nx     = bus.data_in;
            cnt_nx   = W_C;
            state_nx = SHIFT;
          end
          default: begin q_nx = sh_q; so_nx = sh_so; end
        endcase
      end
      SHIFT: begin
        // Abort wins over the final bit, so no done is produced.
        if (bus.abort) begin
          state_nx = IDLE;
        end else begin
          so_nx    = q_r[WIDTH-1];
          q_nx     = {q_r[WIDTH-2:0], bus.serial_in};
          valid_nx = 1'b1;
          cnt_nx   = cnt_r - 1'b1;
          if (cnt_r == CNT_W'(1)) begin
            done_nx  = 1'b1;
            state_nx = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      q_r     <= RST_VAL;
      so_r    <= 1'b0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      cnt_r   <= '0;
    end else begin
      state   <= state_nx;
      q_r     <= q_nx;
      so_r    <= so_nx;
      valid_r <= valid_nx;
      done_r  <= done_nx;
      cnt_r   <= cnt_nx;
    end
  end

  assign bus.q          = q_r;
  assign bus.serial_out = so_r;
  assign bus.ser_valid  = valid_r;
  assign bus.done       = done_r;
  assign bus.busy       = (state == SHIFT);
  assign bus.fsm_state  = state;
endmodule
